// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding control for the 16-bit, 4-register, 5-stage core.
// Sits beside ID and keeps a shadow scoreboard of the instructions in EX,
// MEM and WB. From that scoreboard and the decoded ID fields it produces
// the pipeline enables/flushes and the EX operand forwarding selects.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall and
// flush performance counters (stall_cnt, flush_cnt).
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   stall_cnt         stall cycle counter   (HAZARD_PERF_CNT_EN only)
//   flush_cnt         flush cycle counter   (HAZARD_PERF_CNT_EN only)
//   id_valid          ID holds a real instruction
//   id_opcode         opcode of the ID instruction
//   id_rs, id_rt      source A / source B register addresses
//   id_rd             final destination register
//   id_regwrite       ID instruction writes the register file
//   id_memtoreg       ID instruction is a load
//   ex_branch_taken   branch in EX resolved taken
//   pc_en, ifid_en    PC / IF-ID load enables (combinational)
//   ifid_flush        clear IF/ID to NOP (combinational)
//   idex_bubble       load ID/EX with NOP (combinational)
//   fwd_a, fwd_b      EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   ex_valid, mem_valid, wb_valid  scoreboard valid bits (registered)
module pipe_hazard_ctrl #(
  parameter int REG_AW = 2,
  parameter int OPC_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
);

  // EX slot: everything needed to detect load-use and EX/MEM forwarding.
  logic              ex_valid_q,    ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_load_q,     ex_load_d;
  // MEM slot: a load here already has its data, so its load bit has no use.
  logic              mem_valid_q,    mem_valid_d;
  logic [REG_AW-1:0] mem_rd_q,       mem_rd_d;
  logic              mem_regwrite_q, mem_regwrite_d;
  // WB slot: the regfile writes before it reads, so only occupancy matters.
  logic              wb_valid_q, wb_valid_d;

  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;

  logic              rs_used;
  logic              rt_used;
  logic              ex_prod;
  logic              mem_prod;
  logic              load_use;
  logic              flush;
  logic              stall;
  logic              ex_load_en;
  logic [1:0]        fwd_a_calc;
  logic [1:0]        fwd_b_calc;

  // Decode which sources the ID instruction reads; invalid ID reads nothing.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (id_opcode)
      4'd0:    begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd1:    begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd2:    begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd3:    begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd4:    begin rs_used = 1'b0; rt_used = 1'b1; end
      4'd5:    begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd6:    begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd7:    begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd8:    begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd9:    begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd10:   begin rs_used = 1'b1; rt_used = 1'b0; end
      4'd11:   begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd12:   begin rs_used = 1'b1; rt_used = 1'b1; end
      4'd13:   begin rs_used = 1'b0; rt_used = 1'b1; end
      default: begin rs_used = 1'b0; rt_used = 1'b0; end
    endcase
    if (!id_valid) begin
      rs_used = 1'b0;
      rt_used = 1'b0;
    end else begin
      rs_used = rs_used;
      rt_used = rt_used;
    end
  end

  // Hazard detection and forwarding selection for the instruction in ID.
  always_comb begin
    ex_prod  = ex_valid_q & ex_regwrite_q;
    mem_prod = mem_valid_q & mem_regwrite_q;
    load_use = ex_prod & ex_load_q &
               ((rs_used & (id_rs == ex_rd_q)) | (rt_used & (id_rt == ex_rd_q)));
    flush      = ex_branch_taken & ex_valid_q;
    // A taken branch squashes ID anyway, so it overrides the stall.
    stall      = load_use & ~flush;
    ex_load_en = id_valid & ~stall & ~flush;

    // The EX instruction moves to MEM next cycle (EX/MEM select), the MEM
    // instruction moves to WB (MEM/WB select). Loads in EX never forward:
    // they stall instead.
    if (rs_used & ex_prod & ~ex_load_q & (id_rs == ex_rd_q)) begin
      fwd_a_calc = 2'b01;
    end else if (rs_used & mem_prod & (id_rs == mem_rd_q)) begin
      fwd_a_calc = 2'b10;
    end else begin
      fwd_a_calc = 2'b00;
    end
    if (rt_used & ex_prod & ~ex_load_q & (id_rt == ex_rd_q)) begin
      fwd_b_calc = 2'b01;
    end else if (rt_used & mem_prod & (id_rt == mem_rd_q)) begin
      fwd_b_calc = 2'b10;
    end else begin
      fwd_b_calc = 2'b00;
    end
  end

  // Pipeline enables; reset holds the front end frozen and flushed.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (flush) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  // Scoreboard advance: slots shift every cycle, EX takes ID or a bubble.
  always_comb begin
    wb_valid_d     = mem_valid_q;
    mem_valid_d    = ex_valid_q;
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    ex_valid_d     = 1'b0;
    ex_rd_d        = '0;
    ex_regwrite_d  = 1'b0;
    ex_load_d      = 1'b0;
    fwd_a_d        = 2'b00;
    fwd_b_d        = 2'b00;
    if (ex_load_en) begin
      ex_valid_d    = 1'b1;
      ex_rd_d       = id_rd;
      ex_regwrite_d = id_regwrite;
      ex_load_d     = id_memtoreg;
      fwd_a_d       = fwd_a_calc;
      fwd_b_d       = fwd_b_calc;
    end else begin
      ex_valid_d    = 1'b0;
      ex_rd_d       = '0;
      ex_regwrite_d = 1'b0;
      ex_load_d     = 1'b0;
      fwd_a_d       = 2'b00;
      fwd_b_d       = 2'b00;
    end
  end

  // Scoreboard and forwarding-select registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_load_q      <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_load_q      <= ex_load_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; stall already excludes flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic checked against an in-flight instruction list model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [1:0] id_rs, id_rt, id_rd;
  logic       id_regwrite, id_memtoreg, ex_branch_taken;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       ex_valid, mem_valid, wb_valid;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each in-flight instruction is remembered by what it will write.
  typedef struct packed { bit v; bit [1:0] rd; bit rw; bit ld; } instr_t;
  instr_t m_ex, m_mem, m_wb;
  bit [1:0]  m_fa, m_fb;
  int        m_sc, m_fc;

  function automatic bit reads_a(input logic [3:0] op);
    return id_valid && !(op inside {4'd4, 4'd13, 4'd14, 4'd15});
  endfunction
  function automatic bit reads_b(input logic [3:0] op);
    return id_valid && (op inside {4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd11, 4'd12, 4'd13});
  endfunction
  function automatic bit m_flush();
    return ex_branch_taken && m_ex.v;
  endfunction
  // Load whose data is not ready yet for a register the ID instruction reads.
  function automatic bit m_hazard();
    bit pending;
    pending = m_ex.v && m_ex.rw && m_ex.ld;
    return pending && ((reads_a(id_opcode) && id_rs == m_ex.rd) ||
                       (reads_b(id_opcode) && id_rt == m_ex.rd));
  endfunction
  // Newest older writer of register r decides where the value comes from.
  function automatic bit [1:0] m_source(input bit [1:0] r, input bit used);
    if (!used) return 2'd0;
    if (m_ex.v && m_ex.rw && m_ex.rd == r) return m_ex.ld ? 2'd0 : 2'd1;
    if (m_mem.v && m_mem.rw && m_mem.rd == r) return 2'd2;
    return 2'd0;
  endfunction
  function automatic bit [3:0] m_ctrl();
    if (reset)          return 4'b0011;   // {pc_en, ifid_en, ifid_flush, idex_bubble}
    if (m_flush())      return 4'b1111;
    if (m_hazard())     return 4'b0001;
    return 4'b1100;
  endfunction

  // Model advance, sampled at the same edge as the DUT.
  always @(posedge clk) begin
    if (reset) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_fa <= 2'd0; m_fb <= 2'd0;
      m_sc <= 0; m_fc <= 0;
    end else begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      if (id_valid && !m_flush() && !m_hazard()) begin
        m_ex <= '{v: 1'b1, rd: id_rd, rw: id_regwrite, ld: id_memtoreg};
        m_fa <= m_source(id_rs, reads_a(id_opcode));
        m_fb <= m_source(id_rt, reads_b(id_opcode));
      end else begin
        m_ex <= '0;
        m_fa <= 2'd0;
        m_fb <= 2'd0;
      end
      if (m_flush()) m_fc <= (m_fc == 65535) ? m_fc : m_fc + 1;
      else if (m_hazard()) m_sc <= (m_sc == 65535) ? m_sc : m_sc + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [3:0] op, input bit [1:0] rs,
                       input bit [1:0] rt, input bit [1:0] rd, input bit rw,
                       input bit br);
    id_valid        = v;
    id_opcode       = op;
    id_rs           = rs;
    id_rt           = rt;
    id_rd           = rd;
    id_regwrite     = rw;
    id_memtoreg     = (op == 4'd0);
    ex_branch_taken = br;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd14, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 4'd2, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      total++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0011) begin
        bad++;
        $display("FAIL reset_ctrl: got %b want 0011", {pc_en, ifid_en, ifid_flush, idex_bubble});
      end
      total++;
      if ({fwd_a, fwd_b, ex_valid, mem_valid, wb_valid} !== 7'b0) begin
        bad++;
        $display("FAIL reset_state: got %b want 0000000", {fwd_a, fwd_b, ex_valid, mem_valid, wb_valid});
      end
    end
    reset = 1'b0;
    drive(1'b0, 4'd14, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_release: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_bubble});
    end
    step();
  endtask

  task automatic test_load_use();
    drain();
    drive(1'b1, 4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);   // load r1
    step();
    drive(1'b1, 4'd2, 2'd1, 2'd3, 2'd2, 1'b1, 1'b0);   // add r2 = r1 + r3
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0001) begin
      bad++;
      $display("FAIL load_use_stall: got %b want 0001", {pc_en, ifid_en, ifid_flush, idex_bubble});
    end
    step();
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1100) begin
      bad++;
      $display("FAIL load_use_single: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_bubble});
    end
    step();
    total++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      bad++;
      $display("FAIL load_use_fwd: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_fwd_ex();
    drain();
    drive(1'b1, 4'd3, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);   // addi r1
    step();
    drive(1'b1, 4'd2, 2'd1, 2'd1, 2'd3, 1'b1, 1'b0);
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("FAIL fwd_ex_nostall: got pc_en=%b want 1", pc_en);
    end
    step();
    total++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      bad++;
      $display("FAIL fwd_ex: got a=%b b=%b want a=01 b=01", fwd_a, fwd_b);
    end
  endtask

  task automatic test_fwd_mem();
    drain();
    drive(1'b1, 4'd3, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);   // addi r2
    step();
    drive(1'b1, 4'd14, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);  // NOP
    step();
    drive(1'b1, 4'd5, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    total++;
    if ({fwd_a, fwd_b} !== 4'b0010) begin
      bad++;
      $display("FAIL fwd_mem: got a=%b b=%b want a=00 b=10", fwd_a, fwd_b);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    drive(1'b1, 4'd3, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd2, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd2, 2'd2, 2'd3, 2'd1, 1'b1, 1'b0);
    step();
    total++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      bad++;
      $display("FAIL back_to_back: got a=%b b=%b want a=01 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_flush();
    reset = 1'b1;
    drive(1'b0, 4'd14, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b1, 4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);   // load r1
    step();
    drive(1'b1, 4'd2, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1);   // hazard + taken branch
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1111) begin
      bad++;
      $display("FAIL flush_ctrl: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_bubble});
    end
    step();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_bubble: got ex_valid=%b want 0", ex_valid);
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0}) begin
      bad++;
      $display("FAIL flush_cnt: got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
    end
`endif
    // EX is now a bubble, so the still-asserted branch must be ignored.
    total++;
    if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1100) begin
      bad++;
      $display("FAIL flush_ignored: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_bubble});
    end
    step();
    total++;
    if ({ex_valid, fwd_a} !== 3'b110) begin
      bad++;
      $display("FAIL flush_after: got ex_valid=%b fwd_a=%b want 1 10", ex_valid, fwd_a);
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0}) begin
      bad++;
      $display("FAIL flush_cnt_hold: got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_random();
    bit [3:0] op;
    bit       rw;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      op    = 4'($urandom_range(0, 15));
      rw    = (op == 4'd0) ? 1'b1 : (op >= 4'd14) ? 1'b0 : 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 9) != 0), op, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rw,
            ($urandom_range(0, 5) == 0));
      total++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== m_ctrl()) begin
        bad++;
        $display("FAIL rand_ctrl @%0d: got %b want %b", n, {pc_en, ifid_en, ifid_flush, idex_bubble}, m_ctrl());
      end
      total++;
      if ({fwd_a, fwd_b} !== {m_fa, m_fb}) begin
        bad++;
        $display("FAIL rand_fwd @%0d: got a=%b b=%b want a=%b b=%b", n, fwd_a, fwd_b, m_fa, m_fb);
      end
      total++;
      if ({ex_valid, mem_valid, wb_valid} !== {m_ex.v, m_mem.v, m_wb.v}) begin
        bad++;
        $display("FAIL rand_valid @%0d: got %b want %b", n, {ex_valid, mem_valid, wb_valid}, {m_ex.v, m_mem.v, m_wb.v});
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if ({stall_cnt, flush_cnt} !== {16'(m_sc), 16'(m_fc)}) begin
        bad++;
        $display("FAIL rand_cnt @%0d: got stall=%0d flush=%0d want %0d %0d", n, stall_cnt, flush_cnt, m_sc, m_fc);
      end
`endif
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd14, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_fwd_ex();
    test_fwd_mem();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
